display_decoder: RTL and testbench

Time-display decoder for the microwave front panel: the output end of the keypad encoder path. It latches the four BCD time digits (MM:SS) produced by the encoder/timer logic and drives a multiplexed 4-digit common-anode 7-segment display. A SCAN_DIV prescaler sets the per-digit dwell time. Outputs are glitch-free and registered, with optional leading-zero blanking and a fixed minutes/seconds separator.

---
 rtl/display_decoder_if.sv | 24 ++
 rtl/display_decoder.sv | 131 +++++++++++++
 tb/tb_display_decoder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/display_decoder_if.sv
// Front-panel display bus: latched BCD time digits in, multiplexed
// common-anode 7-segment drive out.
interface display_decoder_if;
   logic       enable;
   logic       load;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       blank_lz;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (
      output enable, load, min_tens, min_ones, sec_tens, sec_ones, blank_lz,
      input  an, seg, dp
   );

   modport slave (
      input  enable, load, min_tens, min_ones, sec_tens, sec_ones, blank_lz,
      output an, seg, dp
   );
endinterface

// File: rtl/display_decoder.sv
// Multiplexed MM:SS display driver: shadow-latched BCD digits, SCAN_DIV
// dwell prescaler, leading-zero blanking and registered active-low drive.
module display_decoder #(
   parameter int unsigned SCAN_DIV = 100
) (
   input  logic              clk,
   input  logic              reset,
   display_decoder_if.slave  bus
);

   localparam logic [7:0] PRE_LAST = 8'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      IDX_SEC_ONES = 2'd0,
      IDX_SEC_TENS = 2'd1,
      IDX_MIN_ONES = 2'd2,
      IDX_MIN_TENS = 2'd3
   } idx_t;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } drive_t;

   localparam drive_t DRIVE_OFF = '{an: 4'b1111, seg: 7'h7F, dp: 1'b1};

   logic [7:0] pre;
   idx_t       idx;
   logic       tick;
   logic [3:0] sh_min_tens;
   logic [3:0] sh_min_ones;
   logic [3:0] sh_sec_tens;
   logic [3:0] sh_sec_ones;
   logic [3:0] digit;
   logic       blank;
   drive_t     drive;
   drive_t     drive_next;

   function automatic logic [6:0] decode(input logic [3:0] value);
      logic [6:0] pattern;
      case (value)
         4'd0:    pattern = 7'h40;
         4'd1:    pattern = 7'h79;
         4'd2:    pattern = 7'h24;
         4'd3:    pattern = 7'h30;
         4'd4:    pattern = 7'h19;
         4'd5:    pattern = 7'h12;
         4'd6:    pattern = 7'h02;
         4'd7:    pattern = 7'h78;
         4'd8:    pattern = 7'h00;
         4'd9:    pattern = 7'h10;
         default: pattern = 7'h3F;
      endcase
      return pattern;
   endfunction

   assign tick = bus.enable && (pre == PRE_LAST);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
      drive_next = DRIVE_OFF;
      digit      = sh_sec_ones;
      blank      = 1'b0;

      case (idx)
         IDX_SEC_ONES: begin
            digit         = sh_sec_ones;
            drive_next.an = 4'b1110;
         end
         IDX_SEC_TENS: begin
            digit         = sh_sec_tens;
            drive_next.an = 4'b1101;
         end
         IDX_MIN_ONES: begin
            digit         = sh_min_ones;
            drive_next.an = 4'b1011;
            drive_next.dp = 1'b0;
            blank         = bus.blank_lz && (sh_min_tens == 4'd0) && (sh_min_ones == 4'd0);
         end
         IDX_MIN_TENS: begin
            digit         = sh_min_tens;
            drive_next.an = 4'b0111;
            blank         = bus.blank_lz && (sh_min_tens == 4'd0);
         end
      endcase

      // A blanked digit keeps its anode but loses the separator.
      drive_next.seg = blank ? 7'h7F : decode(digit);
      if (blank) begin
         drive_next.dp = 1'b1;
      end

      if (!bus.enable) begin
         drive_next = DRIVE_OFF;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         pre         <= '0;
         idx         <= IDX_SEC_ONES;
         // NOTE: shadow digits are reset because blanking and decode read them on the first enabled cycle.
         sh_min_tens <= '0;
         sh_min_ones <= '0;
         sh_sec_tens <= '0;
         sh_sec_ones <= '0;
         drive       <= DRIVE_OFF;
      end else begin
         if (bus.load) begin
            sh_min_tens <= bus.min_tens;
            sh_min_ones <= bus.min_ones;
            sh_sec_tens <= bus.sec_tens;
            sh_sec_ones <= bus.sec_ones;
         end
         if (bus.enable) begin
            pre <= tick ? 8'd0 : pre + 8'd1;
            if (tick) begin
               idx <= idx_t'(idx + 2'd1);
            end
         end
         drive <= drive_next;
      end
   end

   assign bus.an  = drive.an;
   assign bus.seg = drive.seg;
   assign bus.dp  = drive.dp;

endmodule

// File: tb/tb_display_decoder.sv
// Directed bench for display_decoder: a cycle-count model of the scan checks
// every output cycle, and literal expectations pin the key scenarios.
module tb_display_decoder;

   localparam int SD = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   display_decoder_if bus ();

   display_decoder #(.SCAN_DIV(SD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the displayed digit follows from how many enabled cycles have
   // elapsed since reset; outputs lag the state by one edge.
   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int         en_count;
   logic [3:0] m_sh [4];
   logic [3:0] m_an;
   logic [6:0] m_seg;
   logic       m_dp;
   bit         m_valid = 1'b0;

   always @(posedge clk) begin
      int   k;
      logic m_blank;
      if (reset) begin
         en_count = 0;
         m_sh     = '{default: 4'd0};
         m_an     = 4'b1111;
         m_seg    = 7'h7F;
         m_dp     = 1'b1;
         m_valid  = 1'b1;
      end else begin
         k = (en_count / SD) % 4;
         if (bus.enable) begin
            m_blank = bus.blank_lz && ((k == 3 && m_sh[3] == 0) ||
                                       (k == 2 && m_sh[3] == 0 && m_sh[2] == 0));
            m_an    = 4'(~(4'b0001 << k));
            m_seg   = m_blank ? 7'h7F : (m_sh[k] <= 9 ? seg_tab[m_sh[k]] : 7'h3F);
            m_dp    = !(k == 2 && !m_blank);
            en_count++;
         end else begin
            m_an  = 4'b1111;
            m_seg = 7'h7F;
            m_dp  = 1'b1;
         end
         if (bus.load) begin
            m_sh = '{bus.sec_ones, bus.sec_tens, bus.min_ones, bus.min_tens};
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_an", bus.an, m_an);
         check("model_seg", bus.seg, m_seg);
         check("model_dp", bus.dp, m_dp);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Move on to the first output cycle of a fresh dwell on the given anode.
   task automatic wait_new(input logic [3:0] target);
      int n = 0;
      while (bus.an == target && n < 40) begin
         @(negedge clk);
         n++;
      end
      while (bus.an != target && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (bus.an != target) begin
         check("wait_an_timeout", bus.an, target);
      end
   endtask

   task automatic set_digits(input logic [3:0] mt, mo, st, so);
      bus.min_tens = mt;
      bus.min_ones = mo;
      bus.sec_tens = st;
      bus.sec_ones = so;
   endtask

   task automatic expect_drive(input string name, input logic [3:0] an, input logic [6:0] seg,
                               input logic dp);
      check({name, "_an"}, bus.an, an);
      check({name, "_seg"}, bus.seg, seg);
      check({name, "_dp"}, bus.dp, dp);
   endtask

   logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] seg_seq [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

   initial begin
      reset        = 1'b1;
      bus.enable   = 1'b0;
      bus.load     = 1'b0;
      bus.blank_lz = 1'b0;
      set_digits(4'd0, 4'd0, 4'd0, 4'd0);
      step(2);
      expect_drive("reset", 4'b1111, 7'h7F, 1'b1);

      // Scan order with 1,2,3,4 loaded while disabled.
      reset    = 1'b0;
      bus.load = 1'b1;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      step(1);
      bus.load   = 1'b0;
      bus.enable = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step(1);
         expect_drive("scan", an_tab[i / 4], seg_seq[i / 4], (i / 4 == 2) ? 1'b0 : 1'b1);
      end
      step(1);
      check("scan_wrap_an", bus.an, 4'b1110);

      // Leading-zero blanking of both minute digits.
      set_digits(4'd0, 4'd0, 4'd0, 4'd5);
      bus.load     = 1'b1;
      bus.blank_lz = 1'b1;
      step(1);
      bus.load = 1'b0;
      wait_new(4'b1101);
      expect_drive("lz_idx1", 4'b1101, 7'h40, 1'b1);
      wait_new(4'b1011);
      expect_drive("lz_idx2", 4'b1011, 7'h7F, 1'b1);
      wait_new(4'b0111);
      expect_drive("lz_idx3", 4'b0111, 7'h7F, 1'b1);
      wait_new(4'b1110);
      expect_drive("lz_idx0", 4'b1110, 7'h12, 1'b1);

      // Only the minutes tens digit blanks when minutes ones is nonzero.
      set_digits(4'd0, 4'd7, 4'd0, 4'd5);
      bus.load = 1'b1;
      step(1);
      bus.load = 1'b0;
      wait_new(4'b1011);
      expect_drive("lz7_idx2", 4'b1011, 7'h78, 1'b0);
      wait_new(4'b0111);
      expect_drive("lz7_idx3", 4'b0111, 7'h7F, 1'b1);

      // Live inputs are ignored until load; non-BCD shows a dash.
      bus.sec_ones = 4'hC;
      wait_new(4'b1110);
      check("shadow_hold_seg", bus.seg, 7'h12);
      bus.load = 1'b1;
      step(1);
      bus.load = 1'b0;
      wait_new(4'b1110);
      check("nonbcd_seg", bus.seg, 7'h3F);

      // Load on the same edge as the idx 0 -> 1 tick.
      step(2);
      bus.sec_tens = 4'd9;
      bus.load     = 1'b1;
      step(1);
      bus.load = 1'b0;
      check("tick_load_prev_an", bus.an, 4'b1110);
      step(1);
      expect_drive("tick_load", 4'b1101, 7'h10, 1'b1);

      // Disable mid-dwell at idx 2 with pre = 1, then resume.
      wait_new(4'b1011);
      bus.enable = 1'b0;
      step(1);
      expect_drive("disabled", 4'b1111, 7'h7F, 1'b1);
      step(9);
      check("disabled_hold_an", bus.an, 4'b1111);
      bus.enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         expect_drive("resume_idx2", 4'b1011, 7'h78, 1'b0);
      end
      step(1);
      expect_drive("resume_idx3", 4'b0111, 7'h7F, 1'b1);

      // Reset in the middle of the idx 3 dwell.
      reset = 1'b1;
      step(1);
      expect_drive("midreset", 4'b1111, 7'h7F, 1'b1);
      reset = 1'b0;
      step(1);
      expect_drive("post_reset_idx0", 4'b1110, 7'h40, 1'b1);
      bus.blank_lz = 1'b0;
      wait_new(4'b1101);
      check("post_reset_sec_tens", bus.seg, 7'h40);
      wait_new(4'b0111);
      expect_drive("post_reset_idx3", 4'b0111, 7'h40, 1'b1);

      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
